mem_unit_param: RTL

- Parametrised successor to the two-phase fetch/execute memory unit.
- Sits between the CPU core and the storage: on-chip SRAM plus the external LPDDR2 bridge.
- Alternates instruction fetch (PC) and data access (addr_in); generalises SRAM depth, external address width and reset PC.
- Adds a ready/request handshake to external memory, byte-enabled stores, explicit loads and a busy/stall output.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_sram_bank.sv | 29 ++
 rtl/mem_unit_param.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised fetch/execute memory unit:
// the control state encoding, the SRAM/external region select and the NOP word.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IF       = 3'd0,
    ST_IF_CAP   = 3'd1,
    ST_IF_WAIT  = 3'd2,
    ST_EX       = 3'd3,
    ST_MEM_CAP  = 3'd4,
    ST_MEM_WAIT = 3'd5
  } mem_state_e;

  // Instruction substituted when an external fetch is abandoned.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // A word address below the SRAM depth lives in on-chip SRAM; anything else is external.
  function automatic logic in_sram(input logic [31:0] word_addr, input logic [31:0] depth);
    return (word_addr < depth);
  endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// On-chip SRAM bank: 2**SRAM_AW words of 32 bits, four byte-lane write
// enables and a registered read port (one-cycle read latency).
module mem_sram_bank #(
  parameter int SRAM_AW = 12
) (
  input  logic               clk,
  input  logic [3:0]         we,
  input  logic [SRAM_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        q
);

  localparam int DEPTH = 2 ** SRAM_AW;

  logic [31:0] mem_r [DEPTH];
  logic [31:0] q_r;

  // Byte-lane write and synchronous read of the addressed word.
  always_ff @(posedge clk) begin
    if (we[0]) mem_r[addr][7:0]   <= wdata[7:0];
    if (we[1]) mem_r[addr][15:8]  <= wdata[15:8];
    if (we[2]) mem_r[addr][23:16] <= wdata[23:16];
    if (we[3]) mem_r[addr][31:24] <= wdata[31:24];
    q_r <= mem_r[addr];
  end

  assign q = q_r;

endmodule

// File: rtl/mem_unit_param.sv
// Two-phase fetch/execute memory unit between the core and storage
// (on-chip SRAM below SRAM_DEPTH words, external LPDDR2 bridge above).
// Optional feature macro: MEM_TIMEOUT_EN -- bounds external waits to
// TIMEOUT_CYCLES, substitutes NOP/zero data and raises a sticky err flag.
module mem_unit_param
  import mem_pkg::*;
#(
  parameter int          ADDR_W         = 30,
  parameter int          SRAM_AW        = 12,
  parameter int          EXT_AW         = 27,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S,
  input  logic              L,
  input  logic [3:0]        byte_en,
  input  logic [31:0]       next_pc,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       data_in,
  output logic [31:0]       I,
  output logic [31:0]       PC,
  output logic [31:0]       data_out,
  output logic              E,
  output logic              busy,
  output logic              err,
  output logic [EXT_AW-1:0] ext_address,
  output logic [31:0]       ext_write_data,
  output logic [3:0]        ext_byte_en,
  output logic              ext_read_req,
  output logic              ext_write_req,
  input  logic              ext_ready,
  input  logic [31:0]       ext_read_data
);

  localparam logic [31:0] SRAM_DEPTH32 = 32'(2 ** SRAM_AW);

  mem_state_e        state_r, state_n;
  logic [31:0]       pc_r, pc_n;
  logic [31:0]       i_r, i_n;
  logic [31:0]       dout_r, dout_n;
  logic              e_r, busy_r;
  logic              rd_req_r, rd_req_n;
  logic              wr_req_r, wr_req_n;
  logic [EXT_AW-1:0] ext_addr_r, ext_addr_n;
  logic [31:0]       ext_wdata_r, ext_wdata_n;
  logic [3:0]        ext_be_r, ext_be_n;

  logic [31:0]        fetch_wa_s, data_wa_s;
  logic [SRAM_AW-1:0] fetch_sram_addr_s, data_sram_addr_s, sram_addr_s;
  logic [EXT_AW-1:0]  fetch_ext_s, data_ext_s;
  logic [3:0]         sram_we_s, sram_we_gated_s;
  logic [31:0]        sram_q_s;
  logic               timeout_s;

  // Address decode: upper PC bits beyond the word-address field are dropped,
  // external addresses are rebased at SRAM_DEPTH and truncated to EXT_AW.
  assign fetch_wa_s        = 32'(PC[ADDR_W+1:2]);
  assign data_wa_s         = 32'(addr_in);
  assign fetch_sram_addr_s = SRAM_AW'(fetch_wa_s);
  assign data_sram_addr_s  = SRAM_AW'(data_wa_s);
  assign fetch_ext_s       = EXT_AW'(fetch_wa_s - SRAM_DEPTH32);
  assign data_ext_s        = EXT_AW'(data_wa_s - SRAM_DEPTH32);

  // No SRAM write may slip through while reset is held.
  assign sram_we_gated_s = rst ? sram_we_s : 4'b0000;

  mem_sram_bank #(
    .SRAM_AW (SRAM_AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we_gated_s),
    .addr  (sram_addr_s),
    .wdata (data_in),
    .q     (sram_q_s)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_r;
  logic             err_r;
  logic             waiting_s;

  assign waiting_s = (state_r == ST_IF_WAIT) || (state_r == ST_MEM_WAIT);
  assign timeout_s = waiting_s && !ext_ready && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = err_r;

  // Wait-cycle counter (cleared outside waits) and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (waiting_s && !ext_ready && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state, datapath and external-request decisions for each phase.
  always_comb begin
    state_n     = state_r;
    pc_n        = pc_r;
    i_n         = i_r;
    dout_n      = dout_r;
    rd_req_n    = rd_req_r;
    wr_req_n    = wr_req_r;
    ext_addr_n  = ext_addr_r;
    ext_wdata_n = ext_wdata_r;
    ext_be_n    = ext_be_r;
    sram_we_s   = 4'b0000;
    sram_addr_s = fetch_sram_addr_s;
    case (state_r)
      ST_IF: begin
        if (in_sram(fetch_wa_s, SRAM_DEPTH32)) begin
          state_n = ST_IF_CAP;
        end else begin
          rd_req_n    = 1'b1;
          ext_addr_n  = fetch_ext_s;
          ext_wdata_n = 32'h0000_0000;
          ext_be_n    = 4'b0000;
          state_n     = ST_IF_WAIT;
        end
      end
      ST_IF_CAP: begin
        i_n     = sram_q_s;
        state_n = ST_EX;
      end
      ST_IF_WAIT: begin
        if (ext_ready) begin
          i_n      = ext_read_data;
          rd_req_n = 1'b0;
          state_n  = ST_EX;
        end else if (timeout_s) begin
          i_n      = NOP;
          rd_req_n = 1'b0;
          state_n  = ST_EX;
        end else begin
          state_n = ST_IF_WAIT;
        end
      end
      ST_EX: begin
        sram_addr_s = data_sram_addr_s;
        if (S) begin
          if (in_sram(data_wa_s, SRAM_DEPTH32)) begin
            sram_we_s = byte_en;
            pc_n      = next_pc;
            state_n   = ST_IF;
          end else begin
            wr_req_n    = 1'b1;
            ext_addr_n  = data_ext_s;
            ext_wdata_n = data_in;
            ext_be_n    = byte_en;
            state_n     = ST_MEM_WAIT;
          end
        end else if (L) begin
          if (in_sram(data_wa_s, SRAM_DEPTH32)) begin
            state_n = ST_MEM_CAP;
          end else begin
            rd_req_n    = 1'b1;
            ext_addr_n  = data_ext_s;
            ext_wdata_n = 32'h0000_0000;
            ext_be_n    = 4'b0000;
            state_n     = ST_MEM_WAIT;
          end
        end else begin
          pc_n    = next_pc;
          state_n = ST_IF;
        end
      end
      ST_MEM_CAP: begin
        dout_n  = sram_q_s;
        pc_n    = next_pc;
        state_n = ST_IF;
      end
      ST_MEM_WAIT: begin
        if (ext_ready || timeout_s) begin
          // A pending read is a load; an abandoned load returns zero.
          if (rd_req_r) begin
            dout_n = ext_ready ? ext_read_data : 32'h0000_0000;
          end else begin
            dout_n = dout_r;
          end
          rd_req_n    = 1'b0;
          wr_req_n    = 1'b0;
          ext_wdata_n = 32'h0000_0000;
          ext_be_n    = 4'b0000;
          pc_n        = next_pc;
          state_n     = ST_IF;
        end else begin
          state_n = ST_MEM_WAIT;
        end
      end
      default: begin
        state_n = ST_IF;
      end
    endcase
  end

  // State and output registers; reset forces requests low without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IF;
      pc_r        <= RESET_PC;
      i_r         <= 32'h0000_0000;
      dout_r      <= 32'h0000_0000;
      e_r         <= 1'b1;
      busy_r      <= 1'b0;
      rd_req_r    <= 1'b0;
      wr_req_r    <= 1'b0;
      ext_addr_r  <= {EXT_AW{1'b0}};
      ext_wdata_r <= 32'h0000_0000;
      ext_be_r    <= 4'b0000;
    end else begin
      state_r     <= state_n;
      pc_r        <= pc_n;
      i_r         <= i_n;
      dout_r      <= dout_n;
      e_r         <= (state_n == ST_IF) || (state_n == ST_IF_CAP) || (state_n == ST_IF_WAIT);
      busy_r      <= (state_n == ST_IF_WAIT) || (state_n == ST_MEM_WAIT);
      rd_req_r    <= rd_req_n;
      wr_req_r    <= wr_req_n;
      ext_addr_r  <= ext_addr_n;
      ext_wdata_r <= ext_wdata_n;
      ext_be_r    <= ext_be_n;
    end
  end

  assign I              = i_r;
  assign PC             = pc_r;
  assign data_out       = dout_r;
  assign E              = e_r;
  assign busy           = busy_r;
  assign ext_address    = ext_addr_r;
  assign ext_write_data = ext_wdata_r;
  assign ext_byte_en    = ext_be_r;
  assign ext_read_req   = rd_req_r;
  assign ext_write_req  = wr_req_r;

endmodule
